// File: rtl/gvt_reducer.sv
// GVT reduction stage: periodically polls every tile for its LVT, reduces the
// answers to a lexicographic (ts, tb) minimum and publishes it as a monotonic GVT.
module gvt_reducer #(
    parameter int unsigned N_TILES        = 1,
    parameter int unsigned TS_WIDTH       = 32,
    parameter int unsigned TB_WIDTH       = 32,
    parameter int unsigned LOG_GVT_PERIOD = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        lvt_req,
    input  logic [N_TILES-1:0]          lvt_valid,
    input  logic [N_TILES*TS_WIDTH-1:0] lvt_ts,
    input  logic [N_TILES*TB_WIDTH-1:0] lvt_tb,
    output logic                        gvt_valid,
    output logic [TS_WIDTH-1:0]         gvt_ts,
    output logic [TB_WIDTH-1:0]         gvt_tb,
    output logic [15:0]                 overrun_cnt,
    output logic [15:0]                 regress_cnt
);
    localparam int unsigned KEY_W = TS_WIDTH + TB_WIDTH;
    localparam int unsigned IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REDUCE  = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [LOG_GVT_PERIOD-1:0] r_period;
    logic [LOG_GVT_PERIOD-1:0] w_period_nxt;
    logic                      w_tick;
    logic                      w_tick_nxt;
    logic [N_TILES-1:0]        r_bitmap;
    logic [N_TILES-1:0]        w_bitmap_set;
    logic                      w_all_seen;
    logic [KEY_W-1:0]          r_slot [N_TILES];
    logic [IDX_W-1:0]          r_idx;
    logic [KEY_W-1:0]          r_acc;
    logic [KEY_W-1:0]          w_slot_key;
    logic [KEY_W-1:0]          w_acc_min;
    logic [KEY_W-1:0]          w_gvt_key;
    logic                      w_last;
    logic                      r_lvt_req;
    logic                      r_gvt_valid;
    logic [TS_WIDTH-1:0]       r_gvt_ts;
    logic [TB_WIDTH-1:0]       r_gvt_tb;
    logic [CNT_W-1:0]          r_overrun;
    logic [CNT_W-1:0]          r_regress;

    // Keys are {ts, tb}, so a plain unsigned compare is the lexicographic order.
    assign w_period_nxt = r_period + LOG_GVT_PERIOD'(1);
    assign w_tick       = &r_period;
    assign w_tick_nxt   = &w_period_nxt;
    assign w_bitmap_set = r_bitmap | lvt_valid;
    assign w_all_seen   = &w_bitmap_set;
    assign w_last       = (r_state == S_REDUCE) && (r_idx == LAST_IDX);
    assign w_gvt_key    = {r_gvt_ts, r_gvt_tb};
    assign w_acc_min    = (w_slot_key < r_acc) ? w_slot_key : r_acc;

    always_comb begin
        w_slot_key = '0;
        for (int unsigned i = 0; i < N_TILES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_slot_key = r_slot[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_tick) w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_all_seen) w_state_nxt = S_REDUCE;
            S_REDUCE:  if (r_idx == LAST_IDX) w_state_nxt = S_PUBLISH;
            S_PUBLISH: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // lvt_req is registered one cycle early so it lines up with the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period  <= '0;
            r_lvt_req <= 1'b0;
            r_overrun <= '0;
        end else begin
            r_period  <= w_period_nxt;
            r_lvt_req <= w_tick_nxt && (w_state_nxt == S_IDLE);
            if (w_tick && (r_state != S_IDLE) && (r_overrun != '1)) begin
                r_overrun <= r_overrun + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitmap <= '0;
        end else if ((r_state == S_IDLE) && w_tick) begin
            r_bitmap <= '0;
        end else if (r_state == S_COLLECT) begin
            r_bitmap <= w_bitmap_set;
        end
    end

    // Repeated strobes simply overwrite the slot, so the last answer wins.
    always_ff @(posedge clk) begin
        if (r_state == S_COLLECT) begin
            for (int unsigned i = 0; i < N_TILES; i++) begin
                if (lvt_valid[i]) begin
                    r_slot[i] <= {lvt_ts[i*TS_WIDTH +: TS_WIDTH], lvt_tb[i*TB_WIDTH +: TB_WIDTH]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_acc <= '1;
        end else if ((r_state == S_COLLECT) && w_all_seen) begin
            r_idx <= '0;
            r_acc <= '1;
        end else if (r_state == S_REDUCE) begin
            r_acc <= w_acc_min;
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // The final minimum is judged on the last reduce step, so the PUBLISH cycle
    // already shows the pulse together with the updated value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gvt_valid <= 1'b0;
            r_gvt_ts    <= '0;
            r_gvt_tb    <= '0;
            r_regress   <= '0;
        end else begin
            r_gvt_valid <= w_last;
            if (w_last) begin
                if (w_acc_min >= w_gvt_key) begin
                    {r_gvt_ts, r_gvt_tb} <= w_acc_min;
                end else if (r_regress != '1) begin
                    r_regress <= r_regress + CNT_W'(1);
                end
            end
        end
    end

    assign lvt_req     = r_lvt_req;
    assign gvt_valid   = r_gvt_valid;
    assign gvt_ts      = r_gvt_ts;
    assign gvt_tb      = r_gvt_tb;
    assign overrun_cnt = r_overrun;
    assign regress_cnt = r_regress;

endmodule

// File: tb/tb_gvt_reducer.sv
// Scoreboard bench for gvt_reducer: four tiles, 32-cycle period, directed and
// randomised rounds checked against a round-level reference model.
module tb_gvt_reducer;
    localparam int N      = 4;
    localparam int LOGP   = 5;
    localparam int PERIOD = 1 << LOGP;
    localparam logic [31:0] INF = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] ts;
        logic [31:0] tb;
        int          regress;
        int          overrun;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          lvt_req;
    logic [N-1:0]  lvt_valid;
    logic [N*32-1:0] lvt_ts;
    logic [N*32-1:0] lvt_tb;
    logic          gvt_valid;
    logic [31:0]   gvt_ts;
    logic [31:0]   gvt_tb;
    logic [15:0]   overrun_cnt;
    logic [15:0]   regress_cnt;

    gvt_reducer #(
        .N_TILES(N), .TS_WIDTH(32), .TB_WIDTH(32), .LOG_GVT_PERIOD(LOGP)
    ) dut (
        .clk(clk), .rst(rst), .lvt_req(lvt_req), .lvt_valid(lvt_valid),
        .lvt_ts(lvt_ts), .lvt_tb(lvt_tb), .gvt_valid(gvt_valid),
        .gvt_ts(gvt_ts), .gvt_tb(gvt_tb), .overrun_cnt(overrun_cnt),
        .regress_cnt(regress_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tb_cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] mon_ts = '0;
    logic [31:0] mon_tb = '0;

    // Reference model state
    logic [31:0] m_ts [N];
    logic [31:0] m_tb [N];
    logic [31:0] p_ts [N];
    logic [31:0] p_tb [N];
    logic [N-1:0] m_seen = '0;
    logic [N-1:0] p_mask = '0;
    logic [31:0] m_gts = '0;
    logic [31:0] m_gtb = '0;
    int m_regress = 0;
    int m_overrun = 0;
    int m_req_expect = PERIOD - 1;
    int m_last_req = 0;
    bit in_collect = 0;

    always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, tb_cyc);
        end
    endfunction

    // Monitor: pops one expectation per gvt_valid pulse, otherwise checks the hold.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            chk("reset_gvt", {gvt_ts, gvt_tb}, 64'd0);
            chk("reset_flags", 64'({lvt_req, gvt_valid, overrun_cnt, regress_cnt}), 64'd0);
            mon_ts = '0;
            mon_tb = '0;
        end else if (gvt_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_gvt_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("gvt_value", {gvt_ts, gvt_tb}, {mon_e.ts, mon_e.tb});
                chk("gvt_cycle", 64'(tb_cyc), 64'(mon_e.cyc));
                chk("regress_cnt", 64'(regress_cnt), 64'(mon_e.regress));
                chk("overrun_cnt", 64'(overrun_cnt), 64'(mon_e.overrun));
                mon_ts = mon_e.ts;
                mon_tb = mon_e.tb;
            end
        end else begin
            chk("gvt_hold", {gvt_ts, gvt_tb}, {mon_ts, mon_tb});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input int tile, input logic [31:0] ts, input logic [31:0] tb);
        lvt_valid[tile]       = 1'b1;
        lvt_ts[tile*32 +: 32] = ts;
        lvt_tb[tile*32 +: 32] = tb;
        p_mask[tile]          = 1'b1;
        p_ts[tile]            = ts;
        p_tb[tile]            = tb;
    endtask

    task automatic finish_round(input int c);
        logic [31:0] bts;
        logic [31:0] btb;
        int pub;
        bts = INF;
        btb = INF;
        for (int i = 0; i < N; i++) begin
            if (m_ts[i] < bts || (m_ts[i] == bts && m_tb[i] < btb)) begin
                bts = m_ts[i];
                btb = m_tb[i];
            end
        end
        pub = c + N + 1;
        if (bts > m_gts || (bts == m_gts && btb >= m_gtb)) begin
            m_gts = bts;
            m_gtb = btb;
        end else if (m_regress < 65535) begin
            m_regress++;
        end
        // a tick becomes visible in overrun_cnt the cycle after it happens
        for (int k = m_last_req + 1; k < pub; k++)
            if (k % PERIOD == PERIOD - 1 && m_overrun < 65535) m_overrun++;
        exp_q.push_back('{ts: m_gts, tb: m_gtb, regress: m_regress, overrun: m_overrun, cyc: pub});
        if (pub % PERIOD == PERIOD - 1 && m_overrun < 65535) m_overrun++;
        m_req_expect = pub + 1;
        while (m_req_expect % PERIOD != PERIOD - 1) m_req_expect++;
        in_collect = 0;
    endtask

    task automatic commit();
        int c;
        c = tb_cyc;
        if (in_collect) begin
            for (int i = 0; i < N; i++) begin
                if (p_mask[i]) begin
                    m_ts[i]   = p_ts[i];
                    m_tb[i]   = p_tb[i];
                    m_seen[i] = 1'b1;
                end
            end
            if (m_seen == '1) finish_round(c);
        end
        @(negedge clk);
        lvt_valid = '0;
        lvt_ts    = '0;
        lvt_tb    = '0;
        p_mask    = '0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        @(negedge clk);
        while (lvt_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (lvt_req !== 1'b1) chk("lvt_req_timeout", 64'd0, 64'd1);
        else chk("lvt_req_cycle", 64'(tb_cyc), 64'(m_req_expect));
        m_last_req = tb_cyc;
        m_seen     = '0;
        in_collect = 0;
        for (int i = 0; i < N; i++) put(i, 32'd0, 32'd0);
        commit();
        in_collect = 1;
    endtask

    initial begin
        logic [3:0] mask;
        int steps;
        int base;
        int n;
        rst       = 1'b1;
        lvt_valid = '0;
        lvt_ts    = '0;
        lvt_tb    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // minimum of four same-cycle answers, one idle tile
        wait_req();
        put(0, 32'd50, 32'd1); put(1, 32'd20, 32'd9); put(2, 32'd20, 32'd2); put(3, INF, INF);
        commit();
        idle(1);
        for (int i = 0; i < N; i++) put(i, 32'd0, 32'd0);
        commit();

        // staggered answers with an overwrite on tile 2
        wait_req();
        put(2, 32'd40, 32'd0); commit();
        put(0, 32'd60, 32'd0); commit();
        idle(1);
        put(1, 32'd70, 32'd1); commit();
        put(2, 32'd30, 32'd0); commit();
        idle(2);
        put(3, 32'd35, 32'd0); commit();

        wait_req();
        put(0, 32'd100, 32'd5); put(1, INF, INF); put(2, INF, INF); put(3, 32'd200, 32'd0);
        commit();

        // equal result is accepted, not a regression
        wait_req();
        put(0, 32'd100, 32'd9); put(1, 32'd100, 32'd5); put(2, 32'd101, 32'd0); put(3, INF, INF);
        commit();

        wait_req();
        put(0, 32'd150, 32'd0); put(1, 32'd160, 32'd0); put(2, INF, INF); put(3, 32'd99, 32'd7);
        commit();

        // tile 1 silent across three ticks
        wait_req();
        put(0, 32'd200, 32'd0); put(2, 32'd200, 32'd0); put(3, 32'd200, 32'd0);
        commit();
        idle(100);
        put(1, 32'd150, 32'd0);
        commit();

        base = 300;
        for (int r = 0; r < 20; r++) begin
            wait_req();
            steps = 0;
            while (in_collect) begin
                idle($urandom_range(0, 2));
                mask = 4'($urandom_range(1, 15));
                if (steps >= 6) mask = mask | ~m_seen;
                for (int i = 0; i < N; i++) begin
                    if (mask[i]) begin
                        if ($urandom_range(0, 7) == 0) put(i, INF, INF);
                        else put(i, 32'(base + $urandom_range(0, 15)), 32'($urandom_range(0, 7)));
                    end
                end
                commit();
                steps++;
            end
            if ($urandom_range(0, 1) == 1) begin
                put(int'($urandom_range(0, 3)), 32'd0, 32'd0);
                commit();
            end
            base = base + int'($urandom_range(0, 12));
        end

        // every tile idle: GVT moves to infinity
        wait_req();
        for (int i = 0; i < N; i++) put(i, INF, INF);
        commit();
        idle(8);

        // reset with half the bitmap collected
        wait_req();
        put(0, 32'd7, 32'd7); put(2, 32'd8, 32'd8);
        commit();
        idle(2);
        rst = 1'b1;
        chk("queue_empty_at_reset", 64'(exp_q.size()), 64'd0);
        idle(2);
        rst          = 1'b0;
        in_collect   = 0;
        m_seen       = '0;
        m_gts        = '0;
        m_gtb        = '0;
        m_regress    = 0;
        m_overrun    = 0;
        m_req_expect = PERIOD - 1;

        wait_req();
        put(0, 32'd5, 32'd5); put(1, 32'd7, 32'd0); put(2, 32'd5, 32'd6); put(3, INF, INF);
        commit();

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
